// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module : fifo_pkg
// Brief  : Shared constants and helpers for the parametrised FIFO family.
// Rev    : 1.0
// ============================================================================
package fifo_pkg;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module : fifo_ram
// Brief  : DEPTH x DATA_W storage, one synchronous write port, one async read.
// Rev    : 1.0
// ============================================================================
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents are deliberately left uninitialised; occupancy lives in the top.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : fifo_ram
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo_param
// Brief  : Single-clock FIFO with FWFT option, almost flags, count and pulses.
// Rev    : 1.0
// ============================================================================
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          din,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          dout,
    output logic                       valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       wr_ack,
    output logic                       overflow,
    output logic                       underflow,
    output logic [clog2(DEPTH):0]      data_count
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam logic [ADDR_W:0] C_DEPTH    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] C_AF_LEVEL = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] C_AE_LEVEL = (ADDR_W + 1)'(AE_LEVEL);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              full_q,   full_d;
    logic              empty_q,  empty_d;
    logic              af_q,     af_d;
    logic              ae_q,     ae_d;
    logic              wr_ack_q, wr_ack_d;
    logic              ovf_q,    ovf_d;
    logic              udf_q,    udf_d;

    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] ram_rdata;

    // Acceptance uses only registered flags, so a same-cycle read never frees room for a write.
    assign wr_acc = wr_en && !full_q;
    assign rd_acc = rd_en && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
        full_d   = (count_d == C_DEPTH);
        empty_d  = (count_d == '0);
        af_d     = (count_d >= C_AF_LEVEL);
        ae_d     = (count_d <= C_AE_LEVEL);
        wr_ack_d = wr_acc;
        ovf_d    = wr_en && full_q;
        udf_d    = rd_en && empty_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            wr_ack_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            wr_ack_q <= wr_ack_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (din),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            // Head word is always presented; rd_en only acknowledges it.
            assign dout  = ram_rdata;
            assign valid = !empty_q;
        end else begin : g_std
            logic [DATA_W-1:0] dout_q, dout_d;
            logic              valid_q, valid_d;

            always_comb begin
                dout_d  = dout_q;
                valid_d = rd_acc;
                if (rd_acc) begin
                    dout_d = ram_rdata;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    dout_q  <= dout_d;
                    valid_q <= valid_d;
                end
            end

            assign dout  = dout_q;
            assign valid = valid_q;
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign wr_ack       = wr_ack_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign data_count   = count_q;

endmodule : sync_fifo_param
`default_nettype wire
